// File: rtl/m_ttime_pkg.sv
// Shared types and default constants for the ttime cycle-counter sequencer.
package m_ttime_pkg;

    localparam int unsigned PEND_W       = 8;
    localparam int unsigned WDOG_LIMIT   = 63;
    localparam int unsigned START_CYCLES = 64;
    localparam int unsigned ICNT_W       = 6;

    typedef enum logic [1:0] {
        StIdle,
        StAddLo,
        StAddHi,
        StCsr
    } state_e;

endpackage

// File: rtl/m_ttime_ctrl_if.sv
// CSR access port for the ttime counter: request pulses in, data and ack pulse out.
interface m_ttime_ctrl_if;

    logic        csr_rd;
    logic        csr_wr;
    logic        csr_hi;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_ack;

    modport master (
        output csr_rd,
        output csr_wr,
        output csr_hi,
        output csr_wdata,
        input  csr_rdata,
        input  csr_ack
    );

    modport slave (
        input  csr_rd,
        input  csr_wr,
        input  csr_hi,
        input  csr_wdata,
        output csr_rdata,
        output csr_ack
    );

endinterface

// File: rtl/m_ttime_wdog.sv
// Core start-up qualifier (start held for START_CYCLES) and hung-instruction watchdog.
module m_ttime_wdog #(
    parameter int unsigned START_CYCLES = m_ttime_pkg::START_CYCLES,
    parameter int unsigned WDOG_LIMIT   = m_ttime_pkg::WDOG_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic instr_done,
    output logic corerunning,
    output logic buserror
);

    localparam int unsigned StartW = $clog2(START_CYCLES + 1);
    localparam int unsigned WdogW  = $clog2(WDOG_LIMIT + 1);
    localparam logic [StartW-1:0] StartLast = StartW'(START_CYCLES - 1);
    localparam logic [WdogW-1:0]  WdogLast  = WdogW'(WDOG_LIMIT - 1);

    logic [StartW-1:0] startcnt_q;
    logic [WdogW-1:0]  wdog_q;
    logic              running_q;
    logic              buserror_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            startcnt_q <= '0;
            wdog_q     <= '0;
            running_q  <= 1'b0;
            buserror_q <= 1'b0;
        end else begin
            buserror_q <= 1'b0;
            // Saturate so a long-held start cannot wrap the count.
            if (!start) begin
                startcnt_q <= '0;
            end else if (startcnt_q != StartLast) begin
                startcnt_q <= startcnt_q + StartW'(1);
            end
            if (start && startcnt_q == StartLast) begin
                running_q <= 1'b1;
            end
            if (running_q) begin
                if (instr_done) begin
                    wdog_q <= '0;
                end else if (wdog_q == WdogLast) begin
                    wdog_q     <= '0;
                    buserror_q <= 1'b1;
                end else begin
                    wdog_q <= wdog_q + WdogW'(1);
                end
            end
        end
    end

    assign corerunning = running_q;
    assign buserror    = buserror_q;

endmodule

// File: rtl/m_ttime_ctrl.sv
// 64-bit ttime sequencer: drains pending cycle counts through one shared 32-bit adder and
// arbitrates CSR access. Define TTIME_SHADOW_EN for atomic lo/hi read pairs via a shadow.
module m_ttime_ctrl #(
    parameter int unsigned PEND_W       = m_ttime_pkg::PEND_W,
    parameter int unsigned WDOG_LIMIT   = m_ttime_pkg::WDOG_LIMIT,
    parameter int unsigned START_CYCLES = m_ttime_pkg::START_CYCLES
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            instr_done,
    input  logic [m_ttime_pkg::ICNT_W-1:0]  icnt,
    m_ttime_ctrl_if.slave                   csr,
    output logic                            corerunning,
    output logic                            buserror
);

    import m_ttime_pkg::*;

    state_e             state_q;
    logic [PEND_W-1:0]  pend_q;
    logic [PEND_W-1:0]  snap_q;
    logic [31:0]        lo_q;
    logic [31:0]        hi_q;
    logic               req_q;
    logic               req_wr_q;
    logic               req_hi_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic               ack_q;
`ifdef TTIME_SHADOW_EN
    logic [31:0]        shadow_q;
`endif

    logic               done_acc;
    logic               new_req;
    logic [PEND_W-1:0]  inc;
    logic [31:0]        add_a;
    logic [31:0]        add_b;
    logic [32:0]        add_sum;

    m_ttime_wdog #(
        .START_CYCLES (START_CYCLES),
        .WDOG_LIMIT   (WDOG_LIMIT)
    ) u_wdog (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instr_done  (done_acc),
        .corerunning (corerunning),
        .buserror    (buserror)
    );

    assign done_acc = instr_done & corerunning;
    assign new_req  = corerunning & (csr.csr_rd | csr.csr_wr) & ~req_q;
    assign inc      = done_acc ? {{(PEND_W - ICNT_W){1'b0}}, icnt} : '0;

    // One adder serves both halves: snap into lo, then the carry into hi.
    always_comb begin
        add_a = lo_q;
        add_b = {{(32 - PEND_W){1'b0}}, snap_q};
        if (state_q == StAddHi) begin
            add_a = hi_q;
            add_b = 32'd1;
        end
    end

    assign add_sum = {1'b0, add_a} + {1'b0, add_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pend_q   <= '0;
            snap_q   <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            req_q    <= 1'b0;
            req_wr_q <= 1'b0;
            req_hi_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
`ifdef TTIME_SHADOW_EN
            shadow_q <= '0;
`endif
        end else begin
            ack_q  <= 1'b0;
            pend_q <= pend_q + inc;
            if (new_req) begin
                req_q    <= 1'b1;
                req_wr_q <= csr.csr_wr;
                req_hi_q <= csr.csr_hi;
                wdata_q  <= csr.csr_wdata;
            end
            case (state_q)
                StIdle: begin
                    // Access only once drained so reads see every retirement and
                    // writes are never overtaken by a stale add.
                    if (req_q && pend_q == '0) begin
                        state_q <= StCsr;
                    end else if (pend_q != '0) begin
                        snap_q  <= pend_q;
                        pend_q  <= inc;
                        state_q <= StAddLo;
                    end
                end
                StAddLo: begin
                    lo_q    <= add_sum[31:0];
                    state_q <= add_sum[32] ? StAddHi : StIdle;
                end
                StAddHi: begin
                    hi_q    <= add_sum[31:0];
                    state_q <= StIdle;
                end
                StCsr: begin
                    state_q <= StIdle;
                    ack_q   <= 1'b1;
                    req_q   <= 1'b0;
                    if (req_wr_q) begin
                        if (req_hi_q) begin
                            hi_q <= wdata_q;
                        end else begin
                            lo_q <= wdata_q;
                        end
                    end else if (!req_hi_q) begin
                        rdata_q  <= lo_q;
`ifdef TTIME_SHADOW_EN
                        shadow_q <= hi_q;
`endif
                    end else begin
`ifdef TTIME_SHADOW_EN
                        rdata_q <= shadow_q;
`else
                        rdata_q <= hi_q;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign csr.csr_rdata = rdata_q;
    assign csr.csr_ack   = ack_q;

endmodule

// File: tb/tb_m_ttime_ctrl.sv
// Self-checking bench for m_ttime_ctrl against a plain 64-bit arithmetic model of ttime.
module tb_m_ttime_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       instr_done = 1'b0;
    logic [5:0] icnt = '0;
    logic       corerunning;
    logic       buserror;

    m_ttime_ctrl_if csr_if ();

    m_ttime_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instr_done  (instr_done),
        .icnt        (icnt),
        .csr         (csr_if),
        .corerunning (corerunning),
        .buserror    (buserror)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: ttime as one 64-bit number, shadow as last lo-read high word.
    logic [63:0] m_ttime = '0;
    logic [31:0] m_shadow = '0;
    logic        m_run = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [5:0] c);
        instr_done = 1'b1;
        icnt       = c;
        step();
        instr_done = 1'b0;
        icnt       = '0;
        if (m_run) m_ttime += 64'(c);
    endtask

    task automatic csr_op(input logic wr, input logic hi, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        csr_if.csr_rd    = ~wr;
        csr_if.csr_wr    = wr;
        csr_if.csr_hi    = hi;
        csr_if.csr_wdata = wd;
        step();
        csr_if.csr_rd = 1'b0;
        csr_if.csr_wr = 1'b0;
        lat = 0;
        rd  = '0;
        for (int i = 1; i <= 12; i++) begin
            if (csr_if.csr_ack) begin
                lat = i;
                rd  = csr_if.csr_rdata;
                break;
            end
            step();
        end
        check_eq("csr_ack_seen", 64'(lat != 0), 64'd1);
        step();
        check_eq("csr_ack_one_cycle", 64'(csr_if.csr_ack), 64'd0);
    endtask

    task automatic do_read(input logic hi, input string tag, output int lat);
        logic [31:0] rd;
        logic [31:0] exp;
        if (!hi) begin
            exp = m_ttime[31:0];
        end else begin
`ifdef TTIME_SHADOW_EN
            exp = m_shadow;
`else
            exp = m_ttime[63:32];
`endif
        end
        csr_op(1'b0, hi, 32'd0, rd, lat);
        check_eq(tag, 64'(rd), 64'(exp));
        if (!hi) m_shadow = m_ttime[63:32];
    endtask

    task automatic do_write(input logic hi, input logic [31:0] wd);
        logic [31:0] rd;
        int          lat;
        csr_op(1'b1, hi, wd, rd, lat);
        if (hi) m_ttime[63:32] = wd;
        else    m_ttime[31:0]  = wd;
    endtask

    initial begin
        int          lat;
        int          first_k;
        int          second_k;
        int          pulses;
        logic        flag;
        logic [31:0] wd;

        csr_if.csr_rd    = 1'b0;
        csr_if.csr_wr    = 1'b0;
        csr_if.csr_hi    = 1'b0;
        csr_if.csr_wdata = '0;

        #12 rst_n = 1'b1;
        step();
        check_eq("rst_corerunning", 64'(corerunning), 64'd0);
        check_eq("rst_buserror", 64'(buserror), 64'd0);
        check_eq("rst_ack", 64'(csr_if.csr_ack), 64'd0);
        check_eq("rst_rdata", 64'(csr_if.csr_rdata), 64'd0);

        // Start-up: 63 high, 1 low, 64 high; retirements before release are ignored.
        flag  = 1'b0;
        start = 1'b1;
        for (int i = 1; i <= 63; i++) begin
            if (i >= 10 && i <= 12) retire(6'd9);
            else step();
            if (corerunning) flag = 1'b1;
        end
        start = 1'b0;
        step();
        if (corerunning) flag = 1'b1;
        start = 1'b1;
        for (int i = 1; i <= 63; i++) begin
            step();
            if (corerunning) flag = 1'b1;
        end
        check_eq("start_early", 64'(flag), 64'd0);
        step();
        check_eq("start_on_64th", 64'(corerunning), 64'd1);
        m_run = 1'b1;
        do_read(1'b0, "prerun_lo", lat);
        do_read(1'b1, "prerun_hi", lat);

        // Back-to-back retirement, then a second read proves pend fully drained.
        retire(6'd5);
        retire(6'd7);
        retire(6'd63);
        check_eq("b2b_model", m_ttime, 64'd75);
        do_read(1'b0, "b2b_lo", lat);
        do_read(1'b0, "b2b_lo_again", lat);

        // Carry into the high half.
        do_write(1'b0, 32'hFFFF_FFF0);
        do_write(1'b1, 32'h0000_0001);
        retire(6'h20);
        check_eq("carry_model", m_ttime, 64'h0000_0002_0000_0010);
        do_read(1'b0, "carry_lo", lat);
        do_read(1'b1, "carry_hi", lat);

        // Read under load, then a carry between a lo read and its hi read.
        retire(6'd12);
        do_read(1'b0, "load_lo", lat);
        check_eq("load_lat_le4", 64'(lat >= 1 && lat <= 4), 64'd1);
        do_write(1'b0, 32'hFFFF_FFFE);
        do_read(1'b0, "pair_lo", lat);
        retire(6'd5);
        do_read(1'b1, "pair_hi", lat);

        // Watchdog: 63 idle cycles give one pulse, then the count restarts.
        retire(6'd1);
        first_k  = 0;
        second_k = 0;
        pulses   = 0;
        for (int k = 1; k <= 130; k++) begin
            step();
            if (buserror) begin
                pulses++;
                if (first_k == 0) first_k = k;
                else if (second_k == 0) second_k = k;
            end
        end
        check_eq("wdog_first", 64'(first_k), 64'd63);
        check_eq("wdog_second", 64'(second_k), 64'd126);
        check_eq("wdog_pulses", 64'(pulses), 64'd2);

        retire(6'd1);
        pulses = 0;
        for (int k = 1; k <= 100; k++) begin
            if (k == 62) retire(6'd2);
            else step();
            if (buserror) pulses++;
        end
        check_eq("wdog_62_nopulse", 64'(pulses), 64'd0);

        // Randomised retirement bursts interleaved with CSR accesses.
        for (int it = 0; it < 30; it++) begin
            for (int b = 0; b < int'($urandom_range(0, 5)); b++) begin
                if ($urandom_range(0, 3) == 0) step();
                retire(6'($urandom_range(1, 63)));
            end
            case ($urandom_range(0, 3))
                0: do_read(1'b0, "rnd_rd_lo", lat);
                1: do_read(1'b1, "rnd_rd_hi", lat);
                2: begin
                    wd = $urandom;
                    if ($urandom_range(0, 3) == 0) wd = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
                    do_write(1'b0, wd);
                end
                default: do_write(1'b1, $urandom);
            endcase
        end
        do_read(1'b0, "rnd_final_lo", lat);
        do_read(1'b1, "rnd_final_hi", lat);

        // Reset while in ADDHI with a read pending.
        do_write(1'b0, 32'hFFFF_FFF0);
        instr_done       = 1'b1;
        icnt             = 6'h20;
        csr_if.csr_rd    = 1'b1;
        csr_if.csr_hi    = 1'b0;
        step();
        instr_done    = 1'b0;
        icnt          = '0;
        csr_if.csr_rd = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_corerunning", 64'(corerunning), 64'd0);
        check_eq("arst_ack", 64'(csr_if.csr_ack), 64'd0);
        check_eq("arst_rdata", 64'(csr_if.csr_rdata), 64'd0);
        check_eq("arst_buserror", 64'(buserror), 64'd0);
        step();
        step();
        #2 rst_n = 1'b1;
        m_ttime  = '0;
        m_shadow = '0;
        m_run    = 1'b0;
        flag     = 1'b0;
        for (int i = 1; i <= 63; i++) begin
            step();
            if (corerunning || csr_if.csr_ack) flag = 1'b1;
        end
        check_eq("rerun_early_or_ack", 64'(flag), 64'd0);
        step();
        check_eq("rerun_on_64th", 64'(corerunning), 64'd1);
        m_run = 1'b1;
        do_read(1'b0, "rerun_lo", lat);
        do_read(1'b1, "rerun_hi", lat);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
